// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - two-CPU MSI snoop controller arbitrating both caches onto one single-word RAM port
// Optional macro CC_C2C_EN: requester is served from the supplier's data while RAM is updated.
module coherence_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0]              ccwrite,
  input  logic [CPUS-1:0]              cctrans,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic [CPUS-1:0]              ccwait,
  output logic [CPUS-1:0]              ccinv,
  output logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr,
  input  logic [WORD_W-1:0]            ramload,
  input  logic [1:0]                   ramstate,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  output logic                         ramREN,
  output logic                         ramWEN
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, IFETCH, DWB, SNOOP, C2C, RAMRD} state_t;

  state_t state_q, state_d;
  logic   r_q, r_d;
  logic   last_q, last_d;
  logic   o;
  logic   access;

  assign o      = ~r_q;
  assign access = (ramstate == RAM_ACCESS);

  // On a tie the CPU that did not win last time gets the grant.
  function automatic logic pick(input logic [CPUS-1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    last_d      = last_q;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|dWEN) begin
          r_d     = pick(dWEN, last_q);
          last_d  = r_d;
          state_d = DWB;
        end else if (|dREN) begin
          r_d     = pick(dREN, last_q);
          last_d  = r_d;
          state_d = SNOOP;
        end else if (|iREN) begin
          r_d     = pick(iREN, last_q);
          last_d  = r_d;
          state_d = IFETCH;
        end
      end
      IFETCH: begin
        ramREN       = 1'b1;
        ramaddr      = iaddr[r_q];
        iload[r_q]   = ramload;
        if (access) begin
          iwait[r_q] = 1'b0;
          state_d    = IDLE;
        end
      end
      DWB: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr[r_q];
        ramstore     = dstore[r_q];
        if (access) begin
          dwait[r_q] = 1'b0;
          state_d    = IDLE;
        end
      end
      SNOOP: begin
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[r_q];
        ccinv[o]       = ccwrite[r_q];
        if (cctrans[o]) state_d = dWEN[o] ? C2C : RAMRD;
      end
      C2C: begin
        // The snooped cache stays blocked until its dirty word has reached RAM.
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[r_q];
        ccinv[o]       = ccwrite[r_q];
        ramWEN         = 1'b1;
        ramaddr        = daddr[o];
        ramstore       = dstore[o];
`ifdef CC_C2C_EN
        dload[r_q]     = dstore[o];
        if (access) begin
          dwait[r_q] = 1'b0;
          dwait[o]   = 1'b0;
          state_d    = IDLE;
        end
`else
        if (access) begin
          dwait[o] = 1'b0;
          state_d  = RAMRD;
        end
`endif
      end
      RAMRD: begin
        ramREN       = 1'b1;
        ramaddr      = daddr[r_q];
        dload[r_q]   = ramload;
        if (access) begin
          dwait[r_q] = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
